// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between client blocks and the shared-ALU arbiter.
// Clients use the master modport; the arbiter uses the slave modport.
interface alu_rr_arbiter_if #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned OUTPUTSIZE = 16,
    parameter int unsigned OPCODESIZE = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDW        = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATASIZE-1:0]   req_in1;
    logic [NUM_REQ*DATASIZE-1:0]   req_in2;
    logic [NUM_REQ*OPCODESIZE-1:0] req_opcode;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [OUTPUTSIZE-1:0]         rsp_data;
    logic [IDW-1:0]                rsp_id;

    modport master (
        output req_valid, req_in1, req_in2, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with operand latch, registered result and a single backpressured response channel.
module alu_rr_arbiter #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned OUTPUTSIZE = 16,
    parameter int unsigned OPCODESIZE = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_rr_arbiter_if.slave       bus,
    output logic [DATASIZE-1:0]   alu_in1,
    output logic [DATASIZE-1:0]   alu_in2,
    output logic [OPCODESIZE-1:0] alu_opcode,
    input  logic [OUTPUTSIZE-1:0] alu_result,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [IDW-1:0]        rr_ptr_q,     rr_ptr_d;
    logic [DATASIZE-1:0]   alu_in1_q,    alu_in1_d;
    logic [DATASIZE-1:0]   alu_in2_q,    alu_in2_d;
    logic [OPCODESIZE-1:0] alu_opcode_q, alu_opcode_d;
    logic                  rsp_valid_q,  rsp_valid_d;
    logic [OUTPUTSIZE-1:0] rsp_data_q,   rsp_data_d;
    logic [IDW-1:0]        rsp_id_q,     rsp_id_d;
    logic                  busy_q,       busy_d;

    // Per-requester views of the packed operand buses.
    logic [DATASIZE-1:0]   slot_in1 [NUM_REQ];
    logic [DATASIZE-1:0]   slot_in2 [NUM_REQ];
    logic [OPCODESIZE-1:0] slot_op  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign slot_in1[gi] = bus.req_in1[gi*DATASIZE +: DATASIZE];
        assign slot_in2[gi] = bus.req_in2[gi*DATASIZE +: DATASIZE];
        assign slot_op[gi]  = bus.req_opcode[gi*OPCODESIZE +: OPCODESIZE];
    end

    // Winner: first valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   scan_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    logic take_c;
    assign take_c = (state_q == S_IDLE) && grant_found && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (take_c) begin
            bus.req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_opcode_d = alu_opcode_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                if (take_c) begin
                    alu_in1_d    = slot_in1[grant_idx];
                    alu_in2_d    = slot_in2[grant_idx];
                    alu_opcode_d = slot_op[grant_idx];
                    rsp_id_d     = grant_idx;
                    rr_ptr_d     = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = alu_result;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_opcode_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_opcode    = alu_opcode_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter and a local ALU.
module tb_alu_rr_arbiter;

    localparam int DW = 8;
    localparam int OW = 16;
    localparam int CW = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_in1, alu_in2;
    logic [CW-1:0] alu_opcode;
    logic [OW-1:0] alu_result;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int cycle_cnt = 0;
    int grant_q[$];
    int grant_t[$];

    alu_rr_arbiter_if #(.DATASIZE(DW), .OUTPUTSIZE(OW), .OPCODESIZE(CW), .NUM_REQ(NR), .IDW(IW)) bus_if ();

    alu_rr_arbiter #(.DATASIZE(DW), .OUTPUTSIZE(OW), .OPCODESIZE(CW), .NUM_REQ(NR), .IDW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // The ALU instance the arbiter drives.
    function automatic logic [OW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [CW-1:0] op);
        case (op)
            4'd0:  return 16'(a) + 16'(b);
            4'd1:  return 16'(a) - 16'(b);
            4'd2:  return 16'(a) * 16'(b);
            4'd3:  return {8'h00, a & b};
            4'd4:  return {8'h00, a | b};
            4'd5:  return {8'h00, a ^ b};
            4'd6:  return 16'(a) << b[3:0];
            4'd7:  return 16'(a) >> b[2:0];
            4'd8:  return {a, b};
            4'd9:  return {8'h00, ~a};
            4'd10: return {b, a};
            4'd11: return 16'(a < b);
            4'd12: return 16'(a == b);
            4'd13: return {~a, ~b};
            4'd14: return 16'(a) + 16'(b) + 16'd1;
            default: return {a ^ b, a & b};
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_in1, alu_in2, alu_opcode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Transaction-level model: is an op in flight, how many cycles since it was accepted.
    bit            m_busy = 0;
    int            m_age  = 0;
    int            m_ptr  = 0;
    int            m_id   = 0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic [CW-1:0] m_op = '0;
    logic [OW-1:0] m_data = '0;

    always @(negedge clk) begin : cmp
        int         win;
        logic [3:0] exp_ready;
        win = -1;
        exp_ready = '0;
        if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (win < 0 && bus_if.req_valid[idx]) win = idx;
            end
        end
        if (!rst && win >= 0) exp_ready[win] = 1'b1;

        check("req_ready",  32'(bus_if.req_ready), 32'(exp_ready));
        check("busy",       32'(busy),             32'(m_busy));
        check("rsp_valid",  32'(bus_if.rsp_valid), 32'(m_busy && m_age >= 2));
        check("rsp_data",   32'(bus_if.rsp_data),  32'(m_data));
        check("rsp_id",     32'(bus_if.rsp_id),    32'(m_id));
        check("alu_in1",    32'(alu_in1),          32'(m_a));
        check("alu_in2",    32'(alu_in2),          32'(m_b));
        check("alu_opcode", 32'(alu_opcode),       32'(m_op));

        if (rst) begin
            m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_op = '0; m_data = '0;
        end else if (!m_busy && win >= 0) begin
            m_busy = 1;
            m_age  = 1;
            m_id   = win;
            m_a    = bus_if.req_in1[win*DW +: DW];
            m_b    = bus_if.req_in2[win*DW +: DW];
            m_op   = bus_if.req_opcode[win*CW +: CW];
            m_ptr  = (win + 1) % NR;
            grant_q.push_back(win);
            grant_t.push_back(cycle_cnt);
        end else if (m_busy && m_age == 1) begin
            m_age  = 2;
            m_data = alu_ref(m_a, m_b, m_op);
        end else if (m_busy && bus_if.rsp_ready) begin
            m_busy = 0;
            m_age  = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [CW-1:0] op);
        bus_if.req_in1[i*DW +: DW]    = a;
        bus_if.req_in2[i*DW +: DW]    = b;
        bus_if.req_opcode[i*CW +: CW] = op;
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < NR; i++) set_slot(i, DW'($urandom), DW'($urandom), CW'($urandom));
    endtask

    task automatic wait_grants(input int n);
        int guard = 0;
        while (grant_q.size() < n && guard < 60) begin
            cyc(1);
            guard++;
        end
        check("wait_grants", 32'(grant_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy !== 1'b0 && guard < 60) begin
            cyc(1);
            guard++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_rsp();
        int guard = 0;
        while (bus_if.rsp_valid !== 1'b1 && guard < 60) begin
            cyc(1);
            guard++;
        end
        check("wait_rsp", 32'(bus_if.rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            gbase;
        logic [OW-1:0] held_data;

        rst = 1'b1;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b0;
        randomize_slots();
        cyc(3);
        check("reset_busy",      32'(busy),             32'd0);
        check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("reset_req_ready", 32'(bus_if.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_rsp_data", 32'(bus_if.rsp_data), 32'd0);
        check("reset_alu_in1",  32'(alu_in1),         32'd0);

        // Single op from requester 0: 0x0F + 0x03.
        bus_if.rsp_ready = 1'b1;
        set_slot(0, 8'h0F, 8'h03, 4'd0);
        bus_if.req_valid = 4'b0001;
        #1;
        check("t1_req_ready", 32'(bus_if.req_ready), 32'h1);
        cyc(1);
        check("t1_exec_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("t1_exec_busy",      32'(busy),             32'd1);
        bus_if.req_valid = '0;
        cyc(1);
        check("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check("t1_rsp_data",  32'(bus_if.rsp_data),  32'h0012);
        check("t1_rsp_id",    32'(bus_if.rsp_id),    32'd0);
        cyc(1);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Round robin from a fresh pointer with all requesters asking.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        randomize_slots();
        gbase = grant_q.size();
        bus_if.req_valid = 4'b1111;
        wait_grants(gbase + 5);
        bus_if.req_valid = '0;
        wait_idle();
        check("t2_g0", 32'(grant_q[gbase+0]), 32'd0);
        check("t2_g1", 32'(grant_q[gbase+1]), 32'd1);
        check("t2_g2", 32'(grant_q[gbase+2]), 32'd2);
        check("t2_g3", 32'(grant_q[gbase+3]), 32'd3);
        check("t2_g4", 32'(grant_q[gbase+4]), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check("t2_gap", 32'(grant_t[gbase+i] - grant_t[gbase+i-1]), 32'd3);
        end

        // Pointer wrap and skip.
        gbase = grant_q.size();
        bus_if.req_valid = 4'b1000;
        wait_grants(gbase + 1);
        bus_if.req_valid = 4'b0101;
        wait_grants(gbase + 3);
        bus_if.req_valid = '0;
        wait_idle();
        check("t3_g0", 32'(grant_q[gbase+0]), 32'd3);
        check("t3_g1", 32'(grant_q[gbase+1]), 32'd0);
        check("t3_g2", 32'(grant_q[gbase+2]), 32'd2);

        // Backpressure on the response channel.
        bus_if.rsp_ready = 1'b0;
        set_slot(1, 8'hA5, 8'h3C, 4'd2);
        bus_if.req_valid = 4'b0010;
        wait_rsp();
        bus_if.req_valid = 4'b1111;
        held_data = bus_if.rsp_data;
        check("t4_data_val", 32'(held_data), 32'h26AC);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t4_hold_data",  32'(bus_if.rsp_data),  32'(held_data));
            check("t4_hold_id",    32'(bus_if.rsp_id),    32'd1);
            check("t4_hold_ready", 32'(bus_if.req_ready), 32'd0);
        end
        bus_if.rsp_ready = 1'b1;
        cyc(1);
        check("t4_idle_busy",  32'(busy),             32'd0);
        check("t4_idle_ready", 32'(bus_if.req_ready), 32'b0100);
        bus_if.req_valid = '0;

        // Reset while the op is in EXEC.
        bus_if.req_valid = 4'b0100;
        cyc(1);
        check("t5_accepted", 32'(busy), 32'd1);
        rst = 1'b1;
        bus_if.req_valid = '0;
        cyc(1);
        rst = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("t5_rsp_data",  32'(bus_if.rsp_data),  32'd0);
        check("t5_alu_in1",   32'(alu_in1),          32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("t5_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
        end
        gbase = grant_q.size();
        bus_if.req_valid = 4'b1111;
        cyc(1);
        bus_if.req_valid = '0;
        check("t5_grant_cnt", 32'(grant_q.size()), 32'(gbase + 1));
        check("t5_grant_id",  32'(grant_q[gbase]), 32'd0);
        wait_idle();

        // All-ones operands through every opcode.
        for (int op = 0; op < (1 << CW); op++) begin
            set_slot(0, 8'hFF, 8'hFF, CW'(op));
            bus_if.req_valid = 4'b0001;
            cyc(1);
            bus_if.req_valid = '0;
            cyc(1);
            check("t6_rsp_data", 32'(bus_if.rsp_data), 32'(alu_ref(8'hFF, 8'hFF, CW'(op))));
            if (op == 0) check("t6_add_lit", 32'(bus_if.rsp_data), 32'h01FE);
            if (op == 2) check("t6_mul_lit", 32'(bus_if.rsp_data), 32'hFE01);
            if (op == 8) check("t6_cat_lit", 32'(bus_if.rsp_data), 32'hFFFF);
            cyc(1);
        end
        wait_idle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            randomize_slots();
            bus_if.req_valid = 4'($urandom);
            bus_if.rsp_ready = ($urandom % 4) != 0;
            rst = ($urandom % 80) == 0;
            cyc(1);
        end
        rst = 1'b0;
        bus_if.req_valid = '0;
        bus_if.rsp_ready = 1'b1;
        cyc(4);
        check("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
